// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
//   rx_state_e          - receiver frame FSM encoding (5 states)
//   PRESCALE_8/16/32    - legal oversampling ratios
//   DATA_BITS           - data bits per frame
//   FRAME_BITS          - line bits per frame without parity (start + data + stop)
//   FRAME_BITS_PAR      - line bits per frame with parity
package uart_pkg;

  localparam int DATA_BITS      = 8;
  localparam int FRAME_BITS     = DATA_BITS + 2;
  localparam int FRAME_BITS_PAR = DATA_BITS + 3;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

endpackage

// File: rtl/uart_rx_data_sampler.sv
// data_sampler: 3-point majority vote around the middle of each bit.
//   clk, rst_n   - oversampling clock, asynchronous active-low reset
//   rx_in        - serial line
//   edge_cnt     - current oversampling edge inside the bit
//   prescale     - oversampling ratio of the current frame
//   sampled_bit  - majority of the three samples; valid from edge prescale/2+2
module data_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] prescale,
  output logic       sampled_bit
);

  logic [2:0] samples_q, samples_d;
  logic [5:0] mid;

  always_comb begin
    mid       = prescale >> 1;
    samples_d = samples_q;
    if (edge_cnt == mid - 6'd1) samples_d[0] = rx_in;
    if (edge_cnt == mid)        samples_d[1] = rx_in;
    if (edge_cnt == mid + 6'd1) samples_d[2] = rx_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) samples_q <= 3'b111;
    else        samples_q <= samples_d;
  end

  assign sampled_bit = (samples_q[0] & samples_q[1]) |
                       (samples_q[0] & samples_q[2]) |
                       (samples_q[1] & samples_q[2]);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data bits LSB first,
// optional parity, one stop bit, idle-high line).
//   CLK           - oversampling clock (Prescale x bit rate)
//   RST           - asynchronous active-low reset
//   RX_IN         - serial line
//   PAR_EN        - frame carries a parity bit
//   PAR_TYP       - 0 even, 1 odd parity
//   Prescale      - oversampling ratio (8, 16 or 32)
//   P_DATA        - last good received byte
//   data_valid    - one-cycle strobe, P_DATA updated
//   parity_error  - one-cycle strobe, parity mismatch
//   stop_error    - one-cycle strobe, stop bit sampled low
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BITS
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  parity_error,
  output logic                  stop_error
);

  localparam int BCW = $clog2(DATA_WIDTH + 1);

  rx_state_e             state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic                  frame_bad_q, frame_bad_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  data_valid_q, data_valid_d;
  logic                  parity_error_q, parity_error_d;
  logic                  stop_error_q, stop_error_d;
  logic                  sampled_bit;
  logic                  last_edge;

  data_sampler u_sampler (
    .clk         (CLK),
    .rst_n       (RST),
    .rx_in       (RX_IN),
    .edge_cnt    (edge_cnt_q),
    .prescale    (prescale_q),
    .sampled_bit (sampled_bit)
  );

  // ">=" rather than "==" so an illegal Prescale can never strand the counter.
  assign last_edge = (edge_cnt_q >= prescale_q - 6'd1);

  always_comb begin
    state_d        = state_q;
    edge_cnt_d     = edge_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    p_data_d       = p_data_q;
    frame_bad_d    = frame_bad_q;
    par_en_d       = par_en_q;
    par_typ_d      = par_typ_q;
    prescale_d     = prescale_q;
    data_valid_d   = 1'b0;
    parity_error_d = 1'b0;
    stop_error_d   = 1'b0;

    if (state_q != ST_IDLE) begin
      edge_cnt_d = last_edge ? 6'd0 : edge_cnt_q + 6'd1;
    end

    case (state_q)
      ST_IDLE: begin
        edge_cnt_d  = 6'd0;
        bit_cnt_d   = '0;
        frame_bad_d = 1'b0;
        // The detection cycle itself is edge 0 of the start bit.
        if (!RX_IN) begin
          state_d    = ST_START;
          edge_cnt_d = 6'd1;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          prescale_d = Prescale;
        end
      end
      ST_START: begin
        if (last_edge) state_d = sampled_bit ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (last_edge) begin
          shift_d   = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
            state_d = par_en_q ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (last_edge) begin
          if (sampled_bit != ((^shift_q) ^ par_typ_q)) begin
            parity_error_d = 1'b1;
            frame_bad_d    = 1'b1;
          end
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (last_edge) begin
          if (!sampled_bit) begin
            stop_error_d = 1'b1;
          end else if (!frame_bad_q) begin
            p_data_d     = shift_q;
            data_valid_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= ST_IDLE;
      edge_cnt_q     <= 6'd0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      p_data_q       <= '0;
      frame_bad_q    <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= 1'b0;
      prescale_q     <= PRESCALE_8;
      data_valid_q   <= 1'b0;
      parity_error_q <= 1'b0;
      stop_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_cnt_q     <= edge_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      p_data_q       <= p_data_d;
      frame_bad_q    <= frame_bad_d;
      par_en_q       <= par_en_d;
      par_typ_q      <= par_typ_d;
      prescale_q     <= prescale_d;
      data_valid_q   <= data_valid_d;
      parity_error_q <= parity_error_d;
      stop_error_q   <= stop_error_d;
    end
  end

  assign P_DATA       = p_data_q;
  assign data_valid   = data_valid_q;
  assign parity_error = parity_error_q;
  assign stop_error   = stop_error_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx. Each frame pushes its expected
// strobe (kind, P_DATA, cycle) into a queue; a negedge monitor pops and
// compares whenever any strobe is high.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int K_VALID  = 0;
  localparam int K_PARITY = 1;
  localparam int K_STOP   = 2;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_error;
  logic       stop_error;

  int cyc    = 0;
  int checks = 0;
  int fails  = 0;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cycle;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] lastGood;

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .PAR_TYP      (PAR_TYP),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .data_valid   (data_valid),
    .parity_error (parity_error),
    .stop_error   (stop_error)
  );

  // 10 ns oversampling clock; cyc counts rising edges seen so far.
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor: any strobe must match the oldest outstanding expectation.
  exp_t monExp;
  int   monKind;
  always @(negedge CLK) begin
    if (data_valid === 1'b1 || parity_error === 1'b1 || stop_error === 1'b1) begin
      checkOutput("strobe_exclusive", $countones({data_valid, parity_error, stop_error}), 1);
      monKind = data_valid ? K_VALID : (parity_error ? K_PARITY : K_STOP);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_strobe: actual kind=%0d P_DATA=%0h required none (cycle %0d)",
                 monKind, P_DATA, cyc);
      end else begin
        monExp = sb.pop_front();
        checkOutput("strobe_kind", monKind, monExp.kind);
        checkOutput("strobe_p_data", P_DATA, monExp.data);
        checkOutput("strobe_cycle", cyc, monExp.cycle);
      end
    end
  end

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
  endtask

  // Drives one complete frame. glitchBit/glitchEdge invert the line for one
  // oversampling edge of the given frame bit (glitchBit < 0 disables it).
  // expKind/expData are the hand-computed outcome; expAtParity selects the
  // parity bit's end as the strobe time instead of the stop bit's end.
  task automatic applyStimulus(input logic [7:0] data, input logic [5:0] p,
                               input logic parEn, input logic parTyp,
                               input logic parBit, input logic stopBit,
                               input int glitchBit, input int glitchEdge,
                               input int expKind, input logic [7:0] expData);
    logic [10:0] frame;
    int          nbits;
    int          t0;
    exp_t        e;
    nbits    = parEn ? FRAME_BITS_PAR : FRAME_BITS;
    frame    = '1;
    frame[0] = 1'b0;
    for (int i = 0; i < 8; i++) frame[i+1] = data[i];
    if (parEn) begin
      frame[9]  = parBit;
      frame[10] = stopBit;
    end else begin
      frame[9] = stopBit;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int ed = 0; ed < int'(p); ed++) begin
        @(negedge CLK);
        if (b == 0 && ed == 0) begin
          PAR_EN   = parEn;
          PAR_TYP  = parTyp;
          Prescale = p;
          t0       = cyc;
          e.kind   = expKind;
          e.data   = expData;
          e.cycle  = t0 + ((expKind == K_PARITY) ? 10 : nbits) * int'(p);
          sb.push_back(e);
          if (expKind == K_VALID) lastGood = expData;
        end
        // Config must be latched at start detection, so disturb it afterwards.
        if (b == 0 && ed == 1) begin
          PAR_EN   = ~parEn;
          PAR_TYP  = ~parTyp;
          Prescale = (p == PRESCALE_8) ? PRESCALE_32 : PRESCALE_8;
        end
        RX_IN = (b == glitchBit && ed == glitchEdge) ? ~frame[b] : frame[b];
      end
    end
  endtask

  int tg;

  initial begin
    RST      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = PRESCALE_8;
    lastGood = 8'h00;
    #2 RST = 1'b0;
    #1;
    checkOutput("reset_p_data", P_DATA, 8'h00);
    checkOutput("reset_data_valid", data_valid, 1'b0);
    checkOutput("reset_parity_error", parity_error, 1'b0);
    checkOutput("reset_stop_error", stop_error, 1'b0);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    idleCycles(3);

    // Plain frame, no parity: valid at T+80.
    applyStimulus(8'hA5, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, K_VALID, 8'hA5);
    idleCycles(2);
    // Even parity, 0x3C has four ones so parity bit 0 is correct: valid at T+176.
    applyStimulus(8'h3C, PRESCALE_16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, K_VALID, 8'h3C);
    idleCycles(2);
    // Odd parity expects 1, bit sent is 0: parity_error, P_DATA holds 0x3C.
    applyStimulus(8'h3C, PRESCALE_16, 1'b1, 1'b1, 1'b0, 1'b1, -1, 0, K_PARITY, 8'h3C);
    idleCycles(2);
    // Stop bit low: stop_error at T+320, P_DATA holds 0x3C.
    applyStimulus(8'h81, PRESCALE_32, 1'b0, 1'b0, 1'b0, 1'b0, -1, 0, K_STOP, 8'h3C);
    idleCycles(5);

    // Two-cycle low pulse is a false start: no strobes, IDLE again by T+8.
    @(negedge CLK);
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = PRESCALE_8;
    RX_IN    = 1'b0;
    tg       = cyc;
    @(negedge CLK);
    RX_IN = 1'b0;
    @(negedge CLK);
    RX_IN = 1'b1;
    while (cyc < tg + 6) @(negedge CLK);
    checkOutput("false_start_still_start", 32'(dut.state_q), 32'(ST_START));
    while (cyc < tg + 8) @(negedge CLK);
    checkOutput("false_start_idle", 32'(dut.state_q), 32'(ST_IDLE));
    idleCycles(4);

    // Back-to-back frames with zero idle; both have even parity 0.
    applyStimulus(8'h55, PRESCALE_16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, K_VALID, 8'h55);
    applyStimulus(8'hAA, PRESCALE_16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 0, K_VALID, 8'hAA);
    idleCycles(3);

    // Reset in the middle of the data bits of a frame.
    @(negedge CLK);
    PAR_EN   = 1'b0;
    PAR_TYP  = 1'b0;
    Prescale = PRESCALE_8;
    RX_IN    = 1'b0;
    repeat (7) @(negedge CLK);
    repeat (20) begin
      @(negedge CLK);
      RX_IN = 1'b1;
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checkOutput("midframe_reset_p_data", P_DATA, 8'h00);
    checkOutput("midframe_reset_data_valid", data_valid, 1'b0);
    checkOutput("midframe_reset_parity_error", parity_error, 1'b0);
    checkOutput("midframe_reset_stop_error", stop_error, 1'b0);
    lastGood = 8'h00;
    idleCycles(3);
    RST = 1'b1;
    idleCycles(3);
    applyStimulus(8'hC3, PRESCALE_32, 1'b0, 1'b0, 1'b0, 1'b1, -1, 0, K_VALID, 8'hC3);
    idleCycles(2);

    // One-edge low glitch on the centre sample of a '1' data bit.
    applyStimulus(8'hF0, PRESCALE_16, 1'b0, 1'b0, 1'b0, 1'b1, 8, 8, K_VALID, 8'hF0);
    idleCycles(2);
    applyStimulus(8'h0F, PRESCALE_8, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4, K_VALID, 8'h0F);

    for (int i = 0; i < 2000 && sb.size() != 0; i++) @(negedge CLK);
    checkOutput("scoreboard_drain", sb.size(), 0);
    idleCycles(40);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver that consumes the serial line produced by the UART transmitter: 1 start bit, 8 data bits LSB first, optional parity bit, 1 stop bit, idle-high. It sits directly downstream of the transmitter's TX_OUT, or at the chip RX pin. It recovers bit timing from a prescaled clock, majority-votes each bit, checks framing and parity, and presents the byte on a parallel bus with a one-cycle valid strobe.

## Interface
- DATA_WIDTH, 8, number of data bits per frame
- CLK  in  1  oversampling clock, Prescale × bit rate
- RST  in  1  asynchronous active-low reset
- RX_IN  in  1  serial line, idle high
- PAR_EN  in  1  1 = frame carries a parity bit
- PAR_TYP  in  1  0 = even parity, 1 = odd parity
- Prescale  in  6  oversampling ratio; legal values 8, 16, 32
- P_DATA  out  DATA_WIDTH  last received byte
- data_valid  out  1  one-cycle strobe, P_DATA valid
- parity_error  out  1  one-cycle strobe, parity mismatch
- stop_error  out  1  one-cycle strobe, stop bit sampled low

## Operation
- Config latch: PAR_EN, PAR_TYP and Prescale are captured at start detection and held for the whole frame.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - On RX_IN == 0, go to START.
  - Clear edge_cnt and bit_cnt.
- Edge counter:
  - edge_cnt runs 0..Prescale-1 within each bit.
  - It wraps to 0 on the last edge, which also advances the bit.
- Sampler:
  - Samples RX_IN at edge_cnt = Prescale/2-1, Prescale/2 and Prescale/2+1.
  - sampled_bit is the majority of the 3 samples.
  - sampled_bit is valid from edge Prescale/2+2 to the end of the bit.
- START: at the last edge, check sampled_bit.
  - sampled_bit == 1 is a glitch: return to IDLE. No strobes fire.
  - Otherwise go to DATA.
- DATA:
  - At the last edge of each bit, shift sampled_bit into the shift register, LSB first.
  - After bit 7, go to PARITY if PAR_EN, else to STOP.
- PARITY:
  - Expected parity = XOR of the 8 data bits, XOR PAR_TYP.
  - On mismatch, pulse parity_error at the last edge and mark the frame bad.
  - Go to STOP.
- STOP:
  - At the last edge, if sampled_bit == 0, pulse stop_error.
  - If the stop bit is good and the frame is not marked bad:
    - load P_DATA from the shift register;
    - pulse data_valid.
  - Go to IDLE.
- Bad frames never update P_DATA. It holds the last good byte.
- Back-to-back frames: IDLE detects the next start bit on the first cycle after STOP exits. No minimum idle time is required.
- RST low at any time, mid-frame included:
  - state goes to IDLE, counters to 0;
  - P_DATA = 0, and data_valid, parity_error, stop_error = 0;
  - the partial frame is discarded.
- Illegal Prescale values give undefined behaviour but must not lock up. RST recovers the block.

## Timing
- All outputs are registered, and all strobes are exactly 1 cycle wide.
- The start-bit falling edge at cycle T is seen in IDLE at T.
- data_valid is high in cycle T + F·Prescale, with F = 10, or 11 with parity.
- parity_error fires in the cycle after the last edge of the parity bit.
- stop_error and data_valid fire in the same cycle after the last edge of the stop bit.
- The two are mutually exclusive in that cycle.

## Structure
- Shared package uart_pkg holds:
  - state encoding for the 5 states;
  - legal prescale constants PRESCALE_8, PRESCALE_16, PRESCALE_32;
  - frame-length constants.
- The transmitter side uses the same package.
- Sub-module data_sampler: the 3-point majority vote, driven by edge_cnt and Prescale.
- The FSM, edge/bit counters, deserializer and checks stay in uart_rx.

## Test plan
- Prescale=8, PAR_EN=0, send 0xA5 → data_valid at T+80, P_DATA=0xA5, no error strobes.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → data_valid at T+176, P_DATA=0x3C.
- Prescale=16, PAR_EN=1, PAR_TYP=1, send 0x3C with parity 0 (wrong) → parity_error pulse, no data_valid, P_DATA keeps the previous value.
- Prescale=32, send 0x81 with stop bit forced low → stop_error pulse, no data_valid.
- Prescale=8, RX_IN low for 2 cycles then high → no strobes, FSM back in IDLE after 8 cycles.
- Checks with reset and line disturbance:
  - Two back-to-back frames 0x55, 0xAA with zero idle → two data_valid pulses exactly F·Prescale apart.
  - Assert RST mid-DATA → all outputs 0; the next clean frame is received correctly.
  - Apply a 1-cycle low glitch on one sample inside a data bit → the majority vote still gives the correct byte.
